// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcodes, funct codes, ALU operation codes and the
// multicycle control state encoding.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_BREAK = 6'h0D;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_ADDU = 4'b0100;
    localparam logic [3:0] ALU_SUBU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    localparam logic [3:0] S_FETCH       = 4'd0;
    localparam logic [3:0] S_DECODE      = 4'd1;
    localparam logic [3:0] S_R_EXEC      = 4'd2;
    localparam logic [3:0] S_R_WB        = 4'd3;
    localparam logic [3:0] S_MEM_ADDR    = 4'd4;
    localparam logic [3:0] S_MEM_READ_S  = 4'd5;
    localparam logic [3:0] S_MEM_WB      = 4'd6;
    localparam logic [3:0] S_MEM_WRITE_S = 4'd7;
    localparam logic [3:0] S_BRANCH      = 4'd8;
    localparam logic [3:0] S_ADDI_EXEC   = 4'd9;
    localparam logic [3:0] S_ADDI_WB     = 4'd10;
    localparam logic [3:0] S_JUMP        = 4'd11;
    localparam logic [3:0] S_HALT        = 4'd12;

    typedef enum logic [3:0] {
        FETCH       = S_FETCH,
        DECODE      = S_DECODE,
        R_EXEC      = S_R_EXEC,
        R_WB        = S_R_WB,
        MEM_ADDR    = S_MEM_ADDR,
        MEM_READ_S  = S_MEM_READ_S,
        MEM_WB      = S_MEM_WB,
        MEM_WRITE_S = S_MEM_WRITE_S,
        BRANCH      = S_BRANCH,
        ADDI_EXEC   = S_ADDI_EXEC,
        ADDI_WB     = S_ADDI_WB,
        JUMP        = S_JUMP,
        HALT        = S_HALT
    } state_t;

endpackage

// File: rtl/controle_multiciclo_ula_controle.sv
// FUNCT to ALU operation decoder for R-type instructions; valid drops for
// any FUNCT the datapath does not implement.
module ula_controle
    import mips_defs::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_AND;
        valid  = 1'b1;
        case (funct)
            F_ADD:   alu_op = ALU_ADD;
            F_ADDU:  alu_op = ALU_ADDU;
            F_SUB:   alu_op = ALU_SUB;
            F_SUBU:  alu_op = ALU_SUBU;
            F_AND:   alu_op = ALU_AND;
            F_OR:    alu_op = ALU_OR;
            F_XOR:   alu_op = ALU_XOR;
            F_NOR:   alu_op = ALU_NOR;
            F_SLT:   alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// with a memory wait timeout that parks the machine in HALT.
module controle_multiciclo
    import mips_defs::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Z,
    input  logic       MEM_READY,
    output logic       PC_WRITE,
    output logic       PC_WRITE_COND,
    output logic       IOR_D,
    output logic       MEM_READ,
    output logic       MEM_WRITE,
    output logic       IR_WRITE,
    output logic       MEM_TO_REG,
    output logic       REG_DST,
    output logic       REG_WRITE,
    output logic       ALU_SRC_A,
    output logic [1:0] ALU_SRC_B,
    output logic [1:0] PC_SOURCE,
    output logic [3:0] ALU_OP,
    output logic       HALTED
);

    state_t      state, next_state;
    logic [31:0] wait_cnt, wait_inc;
    logic        waiting, timeout;
    logic [3:0]  r_alu_op;
    logic        r_valid;
    logic        unused_z;

    // Z is consumed by the datapath through PC_WRITE_COND, not by the FSM.
    assign unused_z = Z;

    ula_controle u_ula_controle (
        .funct  (FUNCT),
        .alu_op (r_alu_op),
        .valid  (r_valid)
    );

    always_comb begin
        waiting = ((state == FETCH) || (state == MEM_READ_S) || (state == MEM_WRITE_S))
                  && !MEM_READY;
        wait_inc = wait_cnt + 32'd1;
        timeout  = waiting && (MEM_WAIT_MAX != 0) && (wait_inc >= $unsigned(MEM_WAIT_MAX));

        next_state = state;
        case (state)
            FETCH:       if (MEM_READY) next_state = DECODE;
            DECODE: begin
                case (OPCODE)
                    OP_RTYPE:     next_state = (FUNCT == F_BREAK) ? HALT : R_EXEC;
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_ADDI:      next_state = ADDI_EXEC;
                    OP_J:         next_state = JUMP;
                    default:      next_state = HALT;
                endcase
            end
            R_EXEC:      next_state = r_valid ? R_WB : HALT;
            R_WB:        next_state = FETCH;
            MEM_ADDR:    next_state = (OPCODE == OP_LW) ? MEM_READ_S : MEM_WRITE_S;
            MEM_READ_S:  if (MEM_READY) next_state = MEM_WB;
            MEM_WB:      next_state = FETCH;
            MEM_WRITE_S: if (MEM_READY) next_state = FETCH;
            BRANCH:      next_state = FETCH;
            ADDI_EXEC:   next_state = ADDI_WB;
            ADDI_WB:     next_state = FETCH;
            JUMP:        next_state = FETCH;
            default:     next_state = HALT;
        endcase
        if (timeout) next_state = HALT;
    end

    // The wait counter only runs while parked in a memory state; any state change clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state != state)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_inc;
        end
    end

    always_comb begin
        PC_WRITE      = 1'b0;
        PC_WRITE_COND = 1'b0;
        IOR_D         = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        IR_WRITE      = 1'b0;
        MEM_TO_REG    = 1'b0;
        REG_DST       = 1'b0;
        REG_WRITE     = 1'b0;
        ALU_SRC_A     = 1'b0;
        ALU_SRC_B     = 2'b00;
        PC_SOURCE     = 2'b00;
        ALU_OP        = ALU_AND;
        HALTED        = 1'b0;
        case (state)
            FETCH: begin
                MEM_READ  = 1'b1;
                ALU_SRC_B = 2'b01;
                ALU_OP    = ALU_ADD;
                IR_WRITE  = MEM_READY;
                PC_WRITE  = MEM_READY;
            end
            DECODE: begin
                ALU_SRC_B = 2'b11;
                ALU_OP    = ALU_ADD;
            end
            R_EXEC: begin
                ALU_SRC_A = 1'b1;
                ALU_OP    = r_alu_op;
            end
            R_WB: begin
                REG_DST   = 1'b1;
                REG_WRITE = 1'b1;
            end
            MEM_ADDR, ADDI_EXEC: begin
                ALU_SRC_A = 1'b1;
                ALU_SRC_B = 2'b10;
                ALU_OP    = ALU_ADD;
            end
            MEM_READ_S: begin
                MEM_READ = 1'b1;
                IOR_D    = 1'b1;
            end
            MEM_WB: begin
                MEM_TO_REG = 1'b1;
                REG_WRITE  = 1'b1;
            end
            MEM_WRITE_S: begin
                MEM_WRITE = 1'b1;
                IOR_D     = 1'b1;
            end
            BRANCH: begin
                ALU_SRC_A     = 1'b1;
                ALU_OP        = ALU_SUB;
                PC_WRITE_COND = 1'b1;
                PC_SOURCE     = 2'b01;
            end
            ADDI_WB:  REG_WRITE = 1'b1;
            JUMP: begin
                PC_WRITE  = 1'b1;
                PC_SOURCE = 2'b10;
            end
            HALT:     HALTED = 1'b1;
            default:  HALTED = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized bench: each instruction expands into its expected per-cycle output
// sequence, which is played against the DUT and compared cycle by cycle.
module tb_controle_multiciclo;
    import mips_defs::*;

    localparam int WMAX = 15;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] OPCODE = '0, FUNCT = '0;
    logic       Z = 1'b0, MEM_READY = 1'b0;
    logic       PC_WRITE, PC_WRITE_COND, IOR_D, MEM_READ, MEM_WRITE, IR_WRITE;
    logic       MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A, HALTED;
    logic [1:0] ALU_SRC_B, PC_SOURCE;
    logic [3:0] ALU_OP;

    always #5 clock = ~clock;

    controle_multiciclo #(.MEM_WAIT_MAX(WMAX)) dut (
        .clock(clock), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Z(Z),
        .MEM_READY(MEM_READY), .PC_WRITE(PC_WRITE), .PC_WRITE_COND(PC_WRITE_COND),
        .IOR_D(IOR_D), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .IR_WRITE(IR_WRITE),
        .MEM_TO_REG(MEM_TO_REG), .REG_DST(REG_DST), .REG_WRITE(REG_WRITE),
        .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B), .PC_SOURCE(PC_SOURCE),
        .ALU_OP(ALU_OP), .HALTED(HALTED)
    );

    typedef struct packed {
        logic       pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, pc_source;
        logic [3:0] alu_op;
        logic       halted;
    } outs_t;

    typedef struct {
        logic       rst, rdy, z, chk;
        logic [5:0] op, funct;
        outs_t      o;
    } step_t;

    outs_t act;
    assign act = {PC_WRITE, PC_WRITE_COND, IOR_D, MEM_READ, MEM_WRITE, IR_WRITE,
                  MEM_TO_REG, REG_DST, REG_WRITE, ALU_SRC_A, ALU_SRC_B, PC_SOURCE,
                  ALU_OP, HALTED};

    step_t exp_q[$];
    outs_t act_q[$];
    int    n_run = 0, n_fail = 0;

    logic [5:0] valid_f [9] = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT};

    // Reference ALU code table for R-type FUNCT values: {valid, code}
    function automatic logic [4:0] ref_alu(logic [5:0] f);
        case (f)
            6'h20: return {1'b1, 4'b0010};
            6'h21: return {1'b1, 4'b0100};
            6'h22: return {1'b1, 4'b0110};
            6'h23: return {1'b1, 4'b0101};
            6'h24: return {1'b1, 4'b0000};
            6'h25: return {1'b1, 4'b0001};
            6'h26: return {1'b1, 4'b0011};
            6'h27: return {1'b1, 4'b1100};
            6'h2A: return {1'b1, 4'b0111};
            default: return 5'b0;
        endcase
    endfunction

    function automatic outs_t e_fetch(logic rdy);
        outs_t o = '0;
        o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_op = 4'b0010;
        o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction
    function automatic outs_t e_decode();
        outs_t o = '0;
        o.alu_src_b = 2'b11; o.alu_op = 4'b0010;
        return o;
    endfunction
    function automatic outs_t e_rexec(logic [3:0] code);
        outs_t o = '0;
        o.alu_src_a = 1; o.alu_op = code;
        return o;
    endfunction
    function automatic outs_t e_immexec();
        outs_t o = '0;
        o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 4'b0010;
        return o;
    endfunction
    function automatic outs_t e_wb(logic dst, logic m2r);
        outs_t o = '0;
        o.reg_write = 1; o.reg_dst = dst; o.mem_to_reg = m2r;
        return o;
    endfunction
    function automatic outs_t e_mem(logic wr);
        outs_t o = '0;
        o.ior_d = 1; o.mem_read = !wr; o.mem_write = wr;
        return o;
    endfunction
    function automatic outs_t e_branch();
        outs_t o = '0;
        o.alu_src_a = 1; o.alu_op = 4'b0110; o.pc_write_cond = 1; o.pc_source = 2'b01;
        return o;
    endfunction
    function automatic outs_t e_jump();
        outs_t o = '0;
        o.pc_write = 1; o.pc_source = 2'b10;
        return o;
    endfunction
    function automatic outs_t e_halt();
        outs_t o = '0;
        o.halted = 1;
        return o;
    endfunction

    function automatic void push(logic rst, logic rdy, logic [5:0] op, logic [5:0] f,
                                 logic z, logic chk, outs_t o);
        step_t s;
        s.rst = rst; s.rdy = rdy; s.op = op; s.funct = f; s.z = z; s.chk = chk; s.o = o;
        exp_q.push_back(s);
    endfunction

    // Expands one instruction into its expected cycles; wf/wm are not-ready cycles
    // seen in fetch and in the memory access. Returns whether the machine halted.
    task automatic build(input logic [5:0] op, input logic [5:0] f, input int wf,
                         input int wm, input logic z, output bit halted);
        logic [4:0] a;
        halted = 0;
        for (int i = 0; i < wf && i < WMAX; i++) push(0, 0, op, f, z, 1, e_fetch(0));
        if (wf >= WMAX) halted = 1;
        else begin
            push(0, 1, op, f, z, 1, e_fetch(1));
            push(0, 1'($urandom), op, f, z, 1, e_decode());
            if (op == 6'h00) begin
                a = ref_alu(f);
                if (f == 6'h0D) halted = 1;
                else if (!a[4]) begin
                    push(0, 1'($urandom), op, f, z, 0, '0);
                    halted = 1;
                end else begin
                    push(0, 1'($urandom), op, f, z, 1, e_rexec(a[3:0]));
                    push(0, 1'($urandom), op, f, z, 1, e_wb(1, 0));
                end
            end else if (op == 6'h23 || op == 6'h2B) begin
                push(0, 1'($urandom), op, f, z, 1, e_immexec());
                for (int i = 0; i < wm && i < WMAX; i++)
                    push(0, 0, op, f, z, 1, e_mem(op == 6'h2B));
                if (wm >= WMAX) halted = 1;
                else begin
                    push(0, 1, op, f, z, 1, e_mem(op == 6'h2B));
                    if (op == 6'h23) push(0, 1'($urandom), op, f, z, 1, e_wb(0, 1));
                end
            end else if (op == 6'h04) push(0, 1'($urandom), op, f, z, 1, e_branch());
            else if (op == 6'h08) begin
                push(0, 1'($urandom), op, f, z, 1, e_immexec());
                push(0, 1'($urandom), op, f, z, 1, e_wb(0, 0));
            end else if (op == 6'h02) push(0, 1'($urandom), op, f, z, 1, e_jump());
            else halted = 1;
        end
        if (halted) begin
            for (int i = 0; i < 3; i++) push(0, 1'($urandom), op, f, z, 1, e_halt());
            push(1, 1'($urandom), op, f, z, 1, e_halt());
        end
    endtask

    task automatic play_q();
        act_q.delete();
        foreach (exp_q[i]) begin
            reset = exp_q[i].rst; MEM_READY = exp_q[i].rdy; Z = exp_q[i].z;
            OPCODE = exp_q[i].op; FUNCT = exp_q[i].funct;
            @(negedge clock);
            act_q.push_back(act);
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_q.delete();
        push(1, 0, 6'h00, 6'h20, 0, 0, '0);
        push(1, 1, 6'h00, 6'h20, 0, 1, e_fetch(1));
        push(0, 1, 6'h00, 6'h20, 0, 1, e_fetch(1));
        push(0, 0, 6'h00, 6'h20, 0, 1, e_decode());
        play_q();
        foreach (exp_q[i]) if (exp_q[i].chk) begin
            n_run++;
            if (act_q[i] !== exp_q[i].o) begin
                n_fail++;
                $display("FAIL reset step %0d: got %h expected %h", i, act_q[i], exp_q[i].o);
            end
        end
    endtask

    task automatic test_rtype();
        bit h;
        exp_q.delete();
        push(1, 0, 0, 0, 0, 0, '0);
        build(6'h00, 6'h22, 0, 0, 0, h);
        foreach (valid_f[k]) build(6'h00, valid_f[k], $urandom_range(0, 3), 0, 1'($urandom), h);
        build(6'h08, 6'($urandom), 1, 0, 0, h);
        build(6'h02, 6'($urandom), 0, 0, 1, h);
        play_q();
        foreach (exp_q[i]) if (exp_q[i].chk) begin
            n_run++;
            if (act_q[i] !== exp_q[i].o) begin
                n_fail++;
                $display("FAIL rtype step %0d: got %h expected %h", i, act_q[i], exp_q[i].o);
            end
        end
    endtask

    task automatic test_mem_branch();
        bit h;
        exp_q.delete();
        push(1, 0, 0, 0, 0, 0, '0);
        build(6'h23, 6'h11, 0, 3, 0, h);
        build(6'h2B, 6'h05, 2, 2, 0, h);
        build(6'h04, 6'h00, 0, 0, 1, h);
        build(6'h04, 6'h00, 0, 0, 0, h);
        build(6'h23, 6'h00, 0, 0, 1, h);
        play_q();
        foreach (exp_q[i]) if (exp_q[i].chk) begin
            n_run++;
            if (act_q[i] !== exp_q[i].o) begin
                n_fail++;
                $display("FAIL mem_branch step %0d: got %h expected %h", i, act_q[i], exp_q[i].o);
            end
        end
    endtask

    task automatic test_halt();
        bit h;
        exp_q.delete();
        push(1, 0, 0, 0, 0, 0, '0);
        build(6'h00, 6'h0D, 0, 0, 0, h);
        build(6'h3F, 6'h20, 1, 0, 0, h);
        build(6'h00, 6'h3E, 0, 0, 0, h);
        build(6'h08, 6'h00, 0, 0, 0, h);
        play_q();
        foreach (exp_q[i]) if (exp_q[i].chk) begin
            n_run++;
            if (act_q[i] !== exp_q[i].o) begin
                n_fail++;
                $display("FAIL halt step %0d: got %h expected %h", i, act_q[i], exp_q[i].o);
            end
        end
    endtask

    task automatic test_timeout();
        bit h;
        exp_q.delete();
        push(1, 0, 0, 0, 0, 0, '0);
        build(6'h00, 6'h20, WMAX, 0, 0, h);
        build(6'h00, 6'h25, WMAX - 1, 0, 0, h);
        build(6'h23, 6'h00, 0, WMAX, 0, h);
        build(6'h2B, 6'h00, 0, WMAX - 1, 0, h);
        build(6'h2B, 6'h00, 0, WMAX, 0, h);
        play_q();
        foreach (exp_q[i]) if (exp_q[i].chk) begin
            n_run++;
            if (act_q[i] !== exp_q[i].o) begin
                n_fail++;
                $display("FAIL timeout step %0d: got %h expected %h", i, act_q[i], exp_q[i].o);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_q.delete();
        push(1, 0, 0, 0, 0, 0, '0);
        push(0, 1, 6'h2B, 0, 0, 1, e_fetch(1));
        push(0, 0, 6'h2B, 0, 0, 1, e_decode());
        push(0, 0, 6'h2B, 0, 0, 1, e_immexec());
        push(1, 0, 6'h2B, 0, 0, 1, e_mem(1));
        push(0, 0, 6'h2B, 0, 0, 1, e_fetch(0));
        push(0, 1, 6'h2B, 0, 0, 1, e_fetch(1));
        play_q();
        foreach (exp_q[i]) if (exp_q[i].chk) begin
            n_run++;
            if (act_q[i] !== exp_q[i].o) begin
                n_fail++;
                $display("FAIL reset_mid step %0d: got %h expected %h", i, act_q[i], exp_q[i].o);
            end
        end
    endtask

    task automatic test_random();
        bit h;
        logic [5:0] ops [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h00};
        logic [5:0] op, f;
        int wf, wm;
        exp_q.delete();
        push(1, 0, 0, 0, 0, 0, '0);
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : valid_f[$urandom_range(0, 8)];
            wf = ($urandom_range(0, 15) == 0) ? $urandom_range(WMAX - 1, WMAX) : $urandom_range(0, 3);
            wm = ($urandom_range(0, 15) == 0) ? $urandom_range(WMAX - 1, WMAX) : $urandom_range(0, 3);
            build(op, f, wf, wm, 1'($urandom), h);
        end
        play_q();
        foreach (exp_q[i]) if (exp_q[i].chk) begin
            n_run++;
            if (act_q[i] !== exp_q[i].o) begin
                n_fail++;
                $display("FAIL random step %0d: got %h expected %h", i, act_q[i], exp_q[i].o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_mem_branch();
        test_halt();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
